// File: rtl/window_read_scheduler.sv
// window_read_scheduler
// Walks a W x H x C kernel window in column, row, channel order and issues one
// BRAM read per permitted cycle. Addresses come from running row/plane/element
// pointers, so no multipliers are needed. A shift register of issue flags
// matches the BRAM read latency and produces the read-valid and read-last strobes.
module window_read_scheduler #(
    parameter int ADDR_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [31:0]           i_kernel_width,
    input  logic [31:0]           i_kernel_height,
    input  logic [31:0]           i_kernel_channel,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [31:0]           i_row_stride,
    input  logic [31:0]           i_chan_stride,
    input  logic                  i_ready,
    input  logic [31:0]           i_bram_dout,
    output logic                  o_bram_en,
    output logic [ADDR_WIDTH-1:0] o_bram_addr,
    output logic [3:0]            o_bram_we,
    output logic [31:0]           o_rd_data,
    output logic                  o_rd_valid,
    output logic                  o_rd_last,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [31:0]           r_width;
    logic [31:0]           r_height;
    logic [31:0]           r_chan;
    logic [31:0]           r_x;
    logic [31:0]           r_r;
    logic [31:0]           r_c;
    // Strides are held as byte steps (4 * word stride) so every advance is one add.
    logic [ADDR_WIDTH-1:0] r_row_step;
    logic [ADDR_WIDTH-1:0] r_chan_step;
    logic [ADDR_WIDTH-1:0] r_elem_ptr;
    logic [ADDR_WIDTH-1:0] r_row_ptr;
    logic [ADDR_WIDTH-1:0] r_plane_ptr;
    logic [RD_LATENCY-1:0] r_vpipe;
    logic [RD_LATENCY-1:0] r_lpipe;
    logic                  r_done;
    logic                  r_err;

    logic                  w_issue;
    logic                  w_x_end;
    logic                  w_r_end;
    logic                  w_c_end;
    logic                  w_final;
    logic                  w_zero_geom;
    logic [ADDR_WIDTH-1:0] w_next_row;
    logic [ADDR_WIDTH-1:0] w_next_plane;
    logic [RD_LATENCY-1:0] w_vpipe_next;
    logic [RD_LATENCY-1:0] w_lpipe_next;

    assign w_issue      = (r_state == S_ISSUE) && i_ready;
    assign w_x_end      = (r_x == r_width  - 32'd1);
    assign w_r_end      = (r_r == r_height - 32'd1);
    assign w_c_end      = (r_c == r_chan   - 32'd1);
    assign w_final      = w_x_end && w_r_end && w_c_end;
    assign w_zero_geom  = (i_kernel_width == 32'd0) || (i_kernel_height == 32'd0) ||
                          (i_kernel_channel == 32'd0);
    assign w_next_row   = r_row_ptr + r_row_step;
    assign w_next_plane = r_plane_ptr + r_chan_step;

    // Next value of the valid/last pipelines: shift toward the output, insert this cycle's issue.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        w_vpipe_next    = r_vpipe << 1;
        w_lpipe_next    = r_lpipe << 1;
        w_vpipe_next[0] = w_issue;
        w_lpipe_next[0] = w_issue && w_final;
    end

    // Job FSM, window counters, address pointers and read-valid pipeline.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            // NOTE: the pipelines are a few flops, not a memory, so they are cleared on reset
            // to guarantee no stray valid after an abort.
            r_state     <= S_IDLE;
            r_width     <= '0;
            r_height    <= '0;
            r_chan      <= '0;
            r_x         <= '0;
            r_r         <= '0;
            r_c         <= '0;
            r_row_step  <= '0;
            r_chan_step <= '0;
            r_elem_ptr  <= '0;
            r_row_ptr   <= '0;
            r_plane_ptr <= '0;
            r_vpipe     <= '0;
            r_lpipe     <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every branch reads the pre-edge state.
            r_vpipe <= w_vpipe_next;
            r_lpipe <= w_lpipe_next;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_width     <= i_kernel_width;
                        r_height    <= i_kernel_height;
                        r_chan      <= i_kernel_channel;
                        r_row_step  <= ADDR_WIDTH'({i_row_stride, 2'b00});
                        r_chan_step <= ADDR_WIDTH'({i_chan_stride, 2'b00});
                        if (w_zero_geom) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_x         <= '0;
                            r_r         <= '0;
                            r_c         <= '0;
                            r_elem_ptr  <= i_base_addr;
                            r_row_ptr   <= i_base_addr;
                            r_plane_ptr <= i_base_addr;
                            r_state     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (i_ready) begin
                        if (w_x_end) begin
                            r_x <= '0;
                            if (w_r_end) begin
                                r_r         <= '0;
                                r_c         <= r_c + 32'd1;
                                r_plane_ptr <= w_next_plane;
                                r_row_ptr   <= w_next_plane;
                                r_elem_ptr  <= w_next_plane;
                            end else begin
                                r_r        <= r_r + 32'd1;
                                r_row_ptr  <= w_next_row;
                                r_elem_ptr <= w_next_row;
                            end
                        end else begin
                            r_x        <= r_x + 32'd1;
                            r_elem_ptr <= r_elem_ptr + ADDR_WIDTH'(4);
                        end
                        if (w_final) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Leave once the word now at the pipeline output is the last one in flight.
                    if (w_vpipe_next == '0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Enable must follow i_ready in the same cycle; the address is the registered element pointer.
    assign o_bram_en   = w_issue;
    assign o_bram_addr = r_elem_ptr;
    assign o_bram_we   = 4'b0000;
    assign o_rd_data   = i_bram_dout;
    assign o_rd_valid  = r_vpipe[RD_LATENCY-1];
    assign o_rd_last   = r_lpipe[RD_LATENCY-1];
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = r_done;
    assign o_err       = r_err;

endmodule

// File: tb/tb_window_read_scheduler.sv
// Scoreboard bench for window_read_scheduler: two instances (read latency 1 and 3),
// a BRAM model per instance, expected addresses/words queued at job start and
// popped by a monitor whenever the DUT issues or returns a word.
module tb_window_read_scheduler;

    localparam int LAT [2] = '{1, 3};

    logic        clk = 1'b0;
    logic        rst;
    logic        start [2];
    logic        ready [2];
    logic [31:0] kw, kh, kc, base, rs, cs;
    logic [31:0] dout  [2];
    logic        en    [2];
    logic [31:0] addr  [2];
    logic [3:0]  we    [2];
    logic [31:0] rdata [2];
    logic        valid [2];
    logic        last  [2];
    logic        busy  [2];
    logic        done  [2];
    logic        err   [2];

    logic [31:0] q_addr   [2][$];
    logic [32:0] q_data   [2][$];
    int          q_en_cyc [2][$];

    int   n_en [2], n_valid [2], n_done [2];
    int   first_en_cyc [2], last_valid_cyc [2], job_start_cyc [2];
    logic exp_err [2];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    window_read_scheduler #(.ADDR_WIDTH(32), .RD_LATENCY(1)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_start(start[0]),
        .i_kernel_width(kw), .i_kernel_height(kh), .i_kernel_channel(kc),
        .i_base_addr(base), .i_row_stride(rs), .i_chan_stride(cs),
        .i_ready(ready[0]), .i_bram_dout(dout[0]),
        .o_bram_en(en[0]), .o_bram_addr(addr[0]), .o_bram_we(we[0]),
        .o_rd_data(rdata[0]), .o_rd_valid(valid[0]), .o_rd_last(last[0]),
        .o_busy(busy[0]), .o_done(done[0]), .o_err(err[0])
    );

    window_read_scheduler #(.ADDR_WIDTH(32), .RD_LATENCY(3)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start[1]),
        .i_kernel_width(kw), .i_kernel_height(kh), .i_kernel_channel(kc),
        .i_base_addr(base), .i_row_stride(rs), .i_chan_stride(cs),
        .i_ready(ready[1]), .i_bram_dout(dout[1]),
        .o_bram_en(en[1]), .o_bram_addr(addr[1]), .o_bram_we(we[1]),
        .o_rd_data(rdata[1]), .o_rd_valid(valid[1]), .o_rd_last(last[1]),
        .o_busy(busy[1]), .o_done(done[1]), .o_err(err[1])
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // BRAM model: word captured when enabled, delayed to the instance's read latency.
    logic [31:0] bpipe [2][4];
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (en[g]) bpipe[g][0] <= mem_word(addr[g]);
            for (int s = 1; s < 4; s++) bpipe[g][s] <= bpipe[g][s-1];
        end
    end
    always_comb begin
        for (int g = 0; g < 2; g++) dout[g] = bpipe[g][LAT[g]-1];
    end

    // Monitor: compare every issue, returned word and done pulse against the scoreboard.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (en[g]) begin
                check("en_needs_ready", ready[g], 1'b1);
                if (q_addr[g].size() == 0) check("unexpected_en", en[g], 1'b0);
                else check("bram_addr", addr[g], q_addr[g].pop_front());
                if (n_en[g] == 0) first_en_cyc[g] = cyc;
                q_en_cyc[g].push_back(cyc);
                n_en[g]++;
            end
            if (valid[g]) begin
                if (q_data[g].size() == 0) check("unexpected_valid", valid[g], 1'b0);
                else check("rd_last_data", {last[g], rdata[g]}, q_data[g].pop_front());
                if (q_en_cyc[g].size() != 0)
                    check("valid_latency", cyc - q_en_cyc[g].pop_front(), LAT[g]);
                n_valid[g]++;
                last_valid_cyc[g] = cyc;
            end
            if (done[g]) begin
                check("err_flag", err[g], exp_err[g]);
                if (exp_err[g]) check("done_time_err", cyc, job_start_cyc[g]);
                else            check("done_time", cyc, last_valid_cyc[g] + 1);
                n_done[g]++;
            end
        end
    end

    // Queue the expected addresses and words, then pulse start (called #1 after a posedge).
    task automatic start_job(input int g, input logic [31:0] w, input logic [31:0] h,
                             input logic [31:0] c, input logic [31:0] b,
                             input logic [31:0] r, input logic [31:0] s);
        int          total;
        int          idx;
        logic [31:0] a;
        kw = w; kh = h; kc = c; base = b; rs = r; cs = s;
        exp_err[g] = (w == 0) || (h == 0) || (c == 0);
        total = int'(w) * int'(h) * int'(c);
        idx = 0;
        if (!exp_err[g]) begin
            for (int cc = 0; cc < int'(c); cc++)
                for (int rr = 0; rr < int'(h); rr++)
                    for (int xx = 0; xx < int'(w); xx++) begin
                        a = b + ((32'(cc) * s + 32'(rr) * r + 32'(xx)) << 2);
                        q_addr[g].push_back(a);
                        q_data[g].push_back({idx == total - 1, mem_word(a)});
                        idx++;
                    end
        end
        n_en[g] = 0; n_valid[g] = 0; n_done[g] = 0;
        ready[g] = 1'b1;
        start[g] = 1'b1;
        @(posedge clk); #1;
        start[g] = 1'b0;
        job_start_cyc[g] = cyc;
        check("busy_after_start", busy[g], 1'b1);
    endtask

    // Drive ready (mode 0: always 1, mode 1: 1,0,0,1,...) until done, bounded, then check counts.
    task automatic finish_job(input int g, input int mode, input int reads, input bit repulse);
        int k;
        k = 0;
        while (n_done[g] == 0 && k < 300) begin
            ready[g] = (mode == 0) ? 1'b1 : (k % 3 == 0);
            start[g] = repulse && (k == 4);
            @(posedge clk); #1;
            k++;
        end
        start[g] = 1'b0;
        ready[g] = 1'b1;
        @(posedge clk); #1;
        check("done_pulse_count", n_done[g], 1);
        check("en_count", n_en[g], reads);
        check("valid_count", n_valid[g], reads);
        check("addr_queue_empty", q_addr[g].size(), 0);
        check("data_queue_empty", q_data[g].size(), 0);
        check("idle_after_job", busy[g], 1'b0);
        if (mode == 0 && reads > 0) check("first_en_cycle", first_en_cyc[g], job_start_cyc[g]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        rst = 1'b0;
        start = '{1'b0, 1'b0};
        ready = '{1'b1, 1'b1};
        kw = 0; kh = 0; kc = 0; base = 0; rs = 0; cs = 0;
        for (int g = 0; g < 2; g++) begin
            n_en[g] = 0; n_valid[g] = 0; n_done[g] = 0;
            exp_err[g] = 1'b0; last_valid_cyc[g] = 0; job_start_cyc[g] = 0; first_en_cyc[g] = 0;
        end
        #2;
        for (int g = 0; g < 2; g++)
            check("reset_outputs", {en[g], addr[g], we[g], valid[g], last[g], busy[g], done[g], err[g]}, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // 2x2x1, row stride 4, base 0x100: 0x100,0x104,0x110,0x114.
        start_job(0, 2, 2, 1, 32'h100, 4, 0);
        finish_job(0, 0, 4, 1'b0);

        // 3x3x2, row stride 3, channel stride 64: 18 reads, 10th 0x100, last 0x120.
        start_job(0, 3, 3, 2, 0, 3, 64);
        finish_job(0, 0, 18, 1'b0);

        // Same job, ready toggling, start re-pulsed mid-job.
        start_job(0, 3, 3, 2, 0, 3, 64);
        finish_job(0, 1, 18, 1'b1);

        // Zero width: done and err together right after start, no enable.
        start_job(0, 0, 4, 4, 32'h200, 4, 16);
        finish_job(0, 0, 0, 1'b0);

        // Reset asserted at read 5 of 18: immediate abort, no done, no further activity.
        start_job(0, 3, 3, 2, 0, 3, 64);
        k = 0;
        while (n_en[0] < 5 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("reached_read5", n_en[0], 5);
        rst = 1'b0;
        #1;
        check("abort_outputs", {en[0], addr[0], valid[0], last[0], busy[0], done[0], err[0]}, '0);
        q_addr[0].delete(); q_data[0].delete(); q_en_cyc[0].delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("no_done_after_abort", n_done[0], 0);
        check("no_en_after_abort", n_en[0], 5);

        // Clean full job after the abort.
        start_job(0, 3, 3, 2, 0, 3, 64);
        finish_job(0, 0, 18, 1'b0);

        // Read latency 3, 4x1x1: valid 3 cycles after each enable, done 4 after the last.
        start_job(1, 4, 1, 1, 32'h40, 0, 0);
        finish_job(1, 0, 4, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
